// File: rtl/vga_pkg.sv
// Shared timing defaults and elaboration helpers for the VGA scan-out engine.
// Default constants describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Smallest width able to count 0..value-1; never narrower than one bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

  function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Replicates the low b bits of 'bits' MSB-first across 8 bits; the last copy is truncated.
  function automatic logic [7:0] expand8(input logic [7:0] bits, input int b);
    logic [7:0] result;
    result = 8'h00;
    for (int i = 0; i < 8; i++) begin
      result[3'(7 - i)] = bits[3'(b - 1 - (i % b))];
    end
    return result;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a configurable asynchronous reset value,
// used to align sync/blank with the memory read pipeline.
module vga_delay_line #(
  parameter int               WIDTH       = 1,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             vga_clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH*WIDTH-1:0] stage_r;

  generate
    if (DEPTH == 1) begin : g_single
      // Single register stage.
      always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
          stage_r <= RESET_VALUE;
        end else begin
          stage_r <= din;
        end
      end
    end else begin : g_multi
      // New sample enters at the bottom, oldest leaves at the top.
      always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
          stage_r <= {DEPTH{RESET_VALUE}};
        end else begin
          stage_r <= {stage_r[(DEPTH-1)*WIDTH-1:0], din};
        end
      end
    end
  endgenerate

  assign dout = stage_r[DEPTH*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/vga_scanout_engine.sv
// Parametrised VGA timing generator and double-buffered framebuffer scan-out.
// Counters, address and swap logic share the counter domain; DAC pins lag it by 2+MEM_LATENCY.
module vga_scanout_engine
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int SCALE_SHIFT = 2,
  parameter int COLOR_DEPTH = 9,
  parameter int Mn          = 15,
  parameter int MEM_LATENCY = 1
) (
  input  logic                   vga_clock,
  input  logic                   resetn,
  input  logic [COLOR_DEPTH-1:0] pixel_color,
  input  logic                   swap_req,
  output logic [Mn:0]            memory_address,
  output logic                   front_buffer,
  output logic                   swap_pending,
  output logic                   frame_start,
  output logic                   vblank,
  output logic [7:0]             VGA_R,
  output logic [7:0]             VGA_G,
  output logic [7:0]             VGA_B,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   VGA_BLANK_N,
  output logic                   VGA_SYNC_N,
  output logic                   VGA_CLK
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = clog2(H_TOTAL);
  localparam int VW      = clog2(V_TOTAL);
  localparam int CB      = COLOR_DEPTH / 3;
  localparam int COLS    = H_ACTIVE >> SCALE_SHIFT;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYN_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYN_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SWAP    = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_SYN_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYN_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] ROW_MASK  = VW'((32'sd1 <<< SCALE_SHIFT) - 32'sd1);
  localparam logic [Mn-1:0] COL_STEP  = Mn'(COLS);

  logic [HW-1:0] h_r;
  logic [HW-1:0] h_next_s;
  logic [VW-1:0] v_r;
  logic [VW-1:0] v_next_s;
  logic [Mn-1:0] row_base_r;
  logic [Mn-1:0] offset_s;
  logic          h_wrap_s;
  logic          new_row_s;
  logic          active_s;
  logic          hs_level_s;
  logic          vs_level_s;
  logic          swap_point_s;
  logic          active_d_s;
  logic          hs_d_s;
  logic          vs_d_s;
  logic [7:0]    r_bits_s;
  logic [7:0]    g_bits_s;
  logic [7:0]    b_bits_s;

  // Next counter values and decodes of the current raster position.
  always_comb begin
    h_wrap_s = (h_r == H_LAST);
    h_next_s = h_r + HW'(1'b1);
    v_next_s = v_r;
    if (h_wrap_s) begin
      h_next_s = {HW{1'b0}};
      if (v_r == V_LAST) begin
        v_next_s = {VW{1'b0}};
      end else begin
        v_next_s = v_r + VW'(1'b1);
      end
    end else begin
      v_next_s = v_r;
    end
    // A scaled row begins on the first line of each group of 2^SCALE_SHIFT active lines.
    new_row_s    = h_wrap_s && ((v_next_s & ROW_MASK) == {VW{1'b0}}) && (v_next_s < V_ACT_END);
    active_s     = (h_r < H_ACT_END) && (v_r < V_ACT_END);
    hs_level_s   = ((h_r >= H_SYN_BEG) && (h_r < H_SYN_END)) ? HS_POL : ~HS_POL;
    vs_level_s   = ((v_r >= V_SYN_BEG) && (v_r < V_SYN_END)) ? VS_POL : ~VS_POL;
    swap_point_s = h_wrap_s && (v_r == V_SWAP);
    offset_s     = row_base_r + Mn'(h_r >> SCALE_SHIFT);
    r_bits_s     = 8'(pixel_color[COLOR_DEPTH-1 -: CB]);
    g_bits_s     = 8'(pixel_color[2*CB-1 -: CB]);
    b_bits_s     = 8'(pixel_color[CB-1:0]);
  end

  // Raster counters, multiplier-free row base and counter-domain status strobes.
  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      h_r         <= {HW{1'b0}};
      v_r         <= {VW{1'b0}};
      row_base_r  <= {Mn{1'b0}};
      vblank      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_r         <= h_next_s;
      v_r         <= v_next_s;
      vblank      <= (v_next_s >= V_ACT_END);
      frame_start <= (h_r == {HW{1'b0}}) && (v_r == {VW{1'b0}});
      if (h_wrap_s && (v_next_s == {VW{1'b0}})) begin
        row_base_r <= {Mn{1'b0}};
      end else if (new_row_s) begin
        row_base_r <= row_base_r + COL_STEP;
      end else begin
        row_base_r <= row_base_r;
      end
    end
  end

  // Read address follows the active area and holds its last value during blanking.
  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      memory_address <= {(Mn+1){1'b0}};
    end else if (active_s) begin
      memory_address <= {front_buffer, offset_s};
    end else begin
      memory_address <= memory_address;
    end
  end

  // Buffer flip only at the end of the last active line, at most once per frame.
  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      front_buffer <= 1'b0;
      swap_pending <= 1'b0;
    end else if (swap_point_s && (swap_pending || swap_req)) begin
      front_buffer <= ~front_buffer;
      swap_pending <= 1'b0;
    end else if (swap_req) begin
      front_buffer <= front_buffer;
      swap_pending <= 1'b1;
    end else begin
      front_buffer <= front_buffer;
      swap_pending <= swap_pending;
    end
  end

  vga_delay_line #(
    .WIDTH       (3),
    .DEPTH       (MEM_LATENCY + 1),
    .RESET_VALUE ({1'b0, ~HS_POL, ~VS_POL})
  ) u_sync_delay (
    .vga_clock (vga_clock),
    .resetn    (resetn),
    .din       ({active_s, hs_level_s, vs_level_s}),
    .dout      ({active_d_s, hs_d_s, vs_d_s})
  );

  // DAC output register: colour is forced to black outside the delayed active area.
  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      VGA_R       <= 8'h00;
      VGA_G       <= 8'h00;
      VGA_B       <= 8'h00;
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
      VGA_BLANK_N <= 1'b0;
    end else begin
      VGA_HS      <= hs_d_s;
      VGA_VS      <= vs_d_s;
      VGA_BLANK_N <= active_d_s;
      if (active_d_s) begin
        VGA_R <= expand8(r_bits_s, CB);
        VGA_G <= expand8(g_bits_s, CB);
        VGA_B <= expand8(b_bits_s, CB);
      end else begin
        VGA_R <= 8'h00;
        VGA_G <= 8'h00;
        VGA_B <= 8'h00;
      end
    end
  end

  assign VGA_SYNC_N = 1'b1;
  assign VGA_CLK    = vga_clock;

endmodule

// File: tb/tb_vga_scanout_engine.sv
// Directed bench for vga_scanout_engine on a 14x7 raster (8x4 visible, 2x scaling, latency 3).
// A small memory model returns the registered address as pixel data unless a constant pixel is forced.
module tb_vga_scanout_engine;

  logic       vga_clock = 1'b0;
  logic       resetn;
  logic [8:0] pixel_color;
  logic       swap_req;
  logic [3:0] memory_address;
  logic       front_buffer;
  logic       swap_pending;
  logic       frame_start;
  logic       vblank;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic       VGA_SYNC_N;
  logic       VGA_CLK;

  logic [3:0] mem_pipe [3] = '{4'h0, 4'h0, 4'h0};
  logic       const_mode = 1'b0;
  logic [8:0] const_pixel = 9'b101_011_000;
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc_n = 0;
  int         base;

  always #5 vga_clock = ~vga_clock;

  vga_scanout_engine #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .SCALE_SHIFT(1),
    .COLOR_DEPTH(9), .Mn(3), .MEM_LATENCY(3)
  ) dut (
    .vga_clock      (vga_clock),
    .resetn         (resetn),
    .pixel_color    (pixel_color),
    .swap_req       (swap_req),
    .memory_address (memory_address),
    .front_buffer   (front_buffer),
    .swap_pending   (swap_pending),
    .frame_start    (frame_start),
    .vblank         (vblank),
    .VGA_R          (VGA_R),
    .VGA_G          (VGA_G),
    .VGA_B          (VGA_B),
    .VGA_HS         (VGA_HS),
    .VGA_VS         (VGA_VS),
    .VGA_BLANK_N    (VGA_BLANK_N),
    .VGA_SYNC_N     (VGA_SYNC_N),
    .VGA_CLK        (VGA_CLK)
  );

  // Memory with three clocks of read latency; data equals the address.
  always @(posedge vga_clock) begin
    mem_pipe[0] <= memory_address;
    mem_pipe[1] <= mem_pipe[0];
    mem_pipe[2] <= mem_pipe[1];
  end

  assign pixel_color = const_mode ? const_pixel : {5'b00000, mem_pipe[2]};

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc_n, observed, expected);
    end
  endtask

  task automatic next();
    @(negedge vga_clock);
    cyc_n++;
  endtask

  task automatic goto(input int target);
    while (cyc_n < target) next();
  endtask

  function automatic int hk(input int c);
    return c % 14;
  endfunction

  function automatic int vk(input int c);
    return (c / 14) % 7;
  endfunction

  function automatic bit act(input int c);
    return (hk(c) < 8) && (vk(c) < 4);
  endfunction

  function automatic logic [3:0] addr_of(input int c);
    return 4'((vk(c) / 2) * 4 + hk(c) / 2);
  endfunction

  function automatic logic [7:0] exp3(input logic [2:0] x);
    return {x, x, x[2:1]};
  endfunction

  // Cycle-by-cycle expectations from raster position; starts at the cycle reset is released.
  task automatic run_model(input int ncyc);
    logic [3:0] exp_addr;
    logic [3:0] pix_addr;
    logic       exp_bn;
    exp_addr = 4'h0;
    for (int k = 0; k < ncyc; k++) begin
      if (k >= 1 && act(k - 1)) exp_addr = addr_of(k - 1);
      exp_bn   = (k >= 5) && act(k - 5);
      pix_addr = (k >= 5) ? addr_of(k - 5) : 4'h0;
      check("addr", memory_address, exp_addr);
      check("hsync", VGA_HS, (k >= 5 && hk(k - 5) >= 10 && hk(k - 5) < 12) ? 1'b0 : 1'b1);
      check("vsync", VGA_VS, (k >= 5 && vk(k - 5) == 5) ? 1'b1 : 1'b0);
      check("blank_n", VGA_BLANK_N, exp_bn);
      check("rgb_r", VGA_R, 8'h00);
      check("rgb_g", VGA_G, 8'h00);
      check("rgb_b", VGA_B, exp_bn ? exp3(pix_addr[2:0]) : 8'h00);
      check("frame_start", frame_start, (k >= 1 && hk(k - 1) == 0 && vk(k - 1) == 0) ? 1'b1 : 1'b0);
      check("vblank", vblank, (vk(k) >= 4) ? 1'b1 : 1'b0);
      check("front0", front_buffer, 1'b0);
      next();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary in time");
    $fatal(1);
  end

  initial begin
    resetn   = 1'b0;
    swap_req = 1'b0;
    repeat (3) @(negedge vga_clock);

    // Reset values
    check("rst_addr", memory_address, 4'h0);
    check("rst_front", front_buffer, 1'b0);
    check("rst_pending", swap_pending, 1'b0);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_vblank", vblank, 1'b0);
    check("rst_rgb", {VGA_R, VGA_G, VGA_B}, 24'h000000);
    check("rst_blank_n", VGA_BLANK_N, 1'b0);
    check("rst_hs", VGA_HS, 1'b1);
    check("rst_vs", VGA_VS, 1'b0);
    check("sync_n", VGA_SYNC_N, 1'b1);

    // Two full frames of timing, address sequence and pipeline alignment
    resetn = 1'b1;
    cyc_n  = 0;
    run_model(196);

    // Mid-frame request, ignored second request, flip at end of last active line
    base = cyc_n;
    goto(base + 20);
    swap_req = 1'b1;
    next();
    swap_req = 1'b0;
    check("swap_pending_set", swap_pending, 1'b1);
    check("front_before", front_buffer, 1'b0);
    goto(base + 30);
    swap_req = 1'b1;
    next();
    swap_req = 1'b0;
    check("pending_still", swap_pending, 1'b1);
    goto(base + 55);
    check("front_at_swap_point", front_buffer, 1'b0);
    check("pending_at_swap_point", swap_pending, 1'b1);
    next();
    check("front_flipped", front_buffer, 1'b1);
    check("pending_cleared", swap_pending, 1'b0);
    check("addr_hold_blank", memory_address, 4'h7);
    goto(base + 99);
    check("addr_buf1_first", memory_address, 4'h8);
    goto(base + 101);
    check("addr_buf1_x1", memory_address, 4'h9);
    goto(base + 103);
    check("rgb_buf1_g", VGA_G, 8'h24);
    check("rgb_buf1_rb", {VGA_R, VGA_B}, 16'h0000);

    // Only one flip last frame; request on the swap-point cycle flips this frame
    base = base + 98;
    goto(base + 55);
    check("no_second_pending", swap_pending, 1'b0);
    check("front_single_flip", front_buffer, 1'b1);
    swap_req = 1'b1;
    next();
    swap_req = 1'b0;
    check("front_sp_flip", front_buffer, 1'b0);
    check("pending_sp_clear", swap_pending, 1'b0);

    // Colour expansion of 9'b101_011_000 and forced black in blanking
    goto(base + 60);
    const_mode = 1'b1;
    base = base + 98;
    goto(base + 5);
    check("color_r", VGA_R, 8'hB6);
    check("color_g", VGA_G, 8'h6D);
    check("color_b", VGA_B, 8'h00);
    check("color_blank_n", VGA_BLANK_N, 1'b1);
    goto(base + 13);
    check("hblank_rgb", {VGA_R, VGA_G, VGA_B}, 24'h000000);
    check("hblank_blank_n", VGA_BLANK_N, 1'b0);
    goto(base + 61);
    check("vblank_rgb", {VGA_R, VGA_G, VGA_B}, 24'h000000);
    const_mode = 1'b0;

    // Asynchronous reset in the middle of an active line
    base = base + 98;
    goto(base + 3);
    swap_req = 1'b1;
    next();
    swap_req = 1'b0;
    goto(base + 9);
    check("pre_rst_blank_n", VGA_BLANK_N, 1'b1);
    check("pre_rst_b", VGA_B, 8'h49);
    check("pre_rst_pending", swap_pending, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_hs", VGA_HS, 1'b1);
    check("mid_rst_vs", VGA_VS, 1'b0);
    check("mid_rst_blank_n", VGA_BLANK_N, 1'b0);
    check("mid_rst_rgb", {VGA_R, VGA_G, VGA_B}, 24'h000000);
    check("mid_rst_addr", memory_address, 4'h0);
    check("mid_rst_pending", swap_pending, 1'b0);
    check("mid_rst_front", front_buffer, 1'b0);
    check("mid_rst_frame_start", frame_start, 1'b0);
    repeat (2) @(negedge vga_clock);
    resetn = 1'b1;
    cyc_n  = 0;
    run_model(108);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_scanout_engine.md
Name: vga_scanout_engine

Overview:
Parametrised VGA timing generator and framebuffer scan-out engine for the video adaptor; successor to the fixed 640x480 controller.
- Timing (porches, sync widths, polarities), pixel-replication factor, colour depth and memory read latency are all generics.
- Provides a double-buffered framebuffer with tear-free swap at vertical blank.
- Provides frame/line status strobes for drawing logic.
- Sits between video memory (read port) and the VGA DAC pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HS_POL, 0, sync active level (0 = active-low)
VS_POL, 0, sync active level
SCALE_SHIFT, 2, log2 of pixel replication (0..3); COLS = H_ACTIVE>>SCALE_SHIFT, ROWS = V_ACTIVE>>SCALE_SHIFT
COLOR_DEPTH, 9, bits per memory pixel; multiple of 3, max 24
Mn, 15, per-buffer address width; 2^Mn >= COLS*ROWS
MEM_LATENCY, 1, clocks from memory_address to valid pixel_color (1..4)

Ports:
vga_clock  in  1  pixel clock
resetn  in  1  asynchronous active-low reset
pixel_color  in  COLOR_DEPTH  memory read data, packed {R,G,B}
swap_req  in  1  one-cycle request to flip front/back buffer
memory_address  out  Mn+1  {front_buffer, y*COLS + x}
front_buffer  out  1  buffer currently displayed
swap_pending  out  1  swap requested, not yet applied
frame_start  out  1  one-cycle pulse at h=0, v=0
vblank  out  1  high while v >= V_ACTIVE (counter domain)
VGA_R, VGA_G, VGA_B  out  8 each  DAC colour
VGA_HS, VGA_VS  out  1  syncs, polarity per *_POL
VGA_BLANK_N  out  1  high during the active area
VGA_SYNC_N  out  1  constant 1
VGA_CLK  out  1  equals vga_clock

Behaviour:
- Reset values: counters 0; memory_address 0; front_buffer 0; swap_pending 0; frame_start 0; RGB 0; BLANK_N 0; HS = ~HS_POL; VS = ~VS_POL.
- Horizontal counter h: 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters. Wraps to 0.
- Vertical counter v: increments when h wraps; wraps to 0 after V_TOTAL-1.
- Counter widths: clog2 of the totals, computed in the package.
- Sync windows:
  - hsync active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync analogous on v.
  - active = (h < H_ACTIVE) && (v < V_ACTIVE).
- Pipeline (counters at cycle t):
  - stage A: x = h>>SCALE_SHIFT, y = v>>SCALE_SHIFT.
  - memory_address registered at t+1. The offset y*COLS+x uses a multiplier-free form (incremental row base, reset at v=0, +COLS when a new scaled row starts).
  - pixel_color sampled at t+1+MEM_LATENCY.
  - VGA_R/G/B registered at t+2+MEM_LATENCY.
  - HS, VS and BLANK_N pass through an identical delay line, so all DAC outputs align at t+2+MEM_LATENCY.
- memory_address outside the active area: hold the last value (no side effects required of memory).
- Colour expansion:
  - b = COLOR_DEPTH/3; each component's b bits are replicated MSB-first to fill 8 bits, truncating the final copy.
  - Example: b=3, R=3'b101 -> 8'b10110110.
  - Delayed active = 0 forces RGB = 0.
- Buffer swap:
  - swap_req sets swap_pending.
  - Swap point is h == H_TOTAL-1 && v == V_ACTIVE-1 (the cycle before the first blank line). At the swap point, if pending: front_buffer toggles and pending clears on the next edge.
  - swap_req on the swap-point cycle itself is applied in that same swap.
  - Further swap_req while pending has no effect (one flip per frame max).
  - front_buffer never changes during active lines.
- frame_start: registered, high for exactly the one cycle after the counters reach (0,0); never asserted on the first cycle after reset.
- Reset mid-frame: all state returns to reset values asynchronously; scanning restarts at (0,0) with buffer 0.

Decomposition:
- Shared package vga_pkg:
  - clog2 function
  - H_TOTAL/V_TOTAL derivation
  - default 640x480@60 timing constants
  - colour-expansion function expand8(bits, b)
- One sub-module, vga_delay_line (WIDTH, DEPTH shift register with async reset value), reused for the sync/blank alignment.

Test Plan:
1. Default params, run 2 frames -> HS low for 96 clocks starting h=656, period 800; VS low for lines 490-491, period 525 lines; frame_start every 420000 clocks.
2. Small timing (H 8/2/2/2, V 4/1/1/1, SCALE_SHIFT 1, MEM_LATENCY 3), memory model returning data=address -> first active RGB 3+2=5 clocks after (0,0), aligned with BLANK_N rise; address sequence 0,0,1,1,2,2,... per line; line 2 starts at COLS=4.
3. COLOR_DEPTH 9, pixel 9'b101_011_000 -> R=8'hB6, G=8'h6D, B=8'h00; same pixel during blank -> all 0.
4. swap_req mid-frame -> swap_pending=1; front_buffer flips exactly at the end of the last active line; memory_address MSB reads 1 from the next frame.
5. Two swap_req in one frame -> single flip; swap_req on the swap-point cycle -> flip that frame.
6. HS_POL=VS_POL=1 and resetn asserted mid-line -> outputs at reset values immediately (HS=0, VS=0, BLANK_N=0); after release, h counts from 0.
